button_bank: RTL and testbench

BUTTON_BANK -- requirements
Module: button_bank

---
 rtl/button_bank.sv | 132 +++++++++++++
 tb/tb_button_bank.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_bank.sv
// Multi-channel button conditioner. Each channel has:
//   - an input synchroniser, with optional per-channel inversion
//   - a stability-counter debouncer that drives `out`
//   - one-cycle `pressed` and `released` pulses
//   - an optional auto-repeat pulse (`rpt`) while the button is held
// The auto-repeat output is called `rpt` because `repeat` is a reserved word.
module button_bank #(
  parameter int                  CHANNELS      = 4,
  parameter int                  CLOCK_CYCLES  = 1_000_000,
  parameter int                  SYNC_STAGES   = 2,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW    = '0,
  parameter int                  REPEAT_DELAY  = 50_000_000,
  parameter int                  REPEAT_PERIOD = 10_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] released,
  output logic [CHANNELS-1:0] rpt
);

  // The stability counter only ever needs to reach CLOCK_CYCLES-1.
  localparam int               CNT_W   = ($clog2(CLOCK_CYCLES) > 0) ? $clog2(CLOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLOCK_CYCLES - 1);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   cand_reg;
      logic [CNT_W-1:0]       cnt_reg;
      logic                   out_q;
      logic                   press_q;
      logic                   rel_q;
      logic                   sync_bit;
      logic                   accept;
      logic                   fall;

      assign sync_bit = sync_reg[SYNC_STAGES-1];

      // The candidate has been stable long enough and differs from the
      // current output, so `out` takes the candidate on this edge.
      assign accept = (sync_bit == cand_reg) && (cnt_reg == CNT_MAX) &&
                      (out_q != cand_reg);
      assign fall   = accept & ~cand_reg;

      // Shift the polarity-corrected raw level through the synchroniser chain.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], in[gi] ^ ACTIVE_LOW[gi]};
        end
      end

      // Debounce: a change at the synchroniser output restarts the count.
      // Once the count saturates, the candidate level is accepted and the
      // matching edge pulse is emitted.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cand_reg <= 1'b0;
          cnt_reg  <= '0;
          out_q    <= 1'b0;
          press_q  <= 1'b0;
          rel_q    <= 1'b0;
        end else begin
          press_q <= 1'b0;
          rel_q   <= 1'b0;
          if (sync_bit != cand_reg) begin
            cand_reg <= sync_bit;
            cnt_reg  <= '0;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 1'b1;
          end else if (accept) begin
            out_q   <= cand_reg;
            press_q <= cand_reg;
            rel_q   <= ~cand_reg;
          end
        end
      end

      assign out[gi]      = out_q;
      assign pressed[gi]  = press_q;
      assign released[gi] = rel_q;

      if (REPEAT_DELAY != 0) begin : g_rep
        localparam int HOLD_SPAN = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int HOLD_W    = ($clog2(HOLD_SPAN) > 0) ? $clog2(HOLD_SPAN) : 1;
        localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
        localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

        logic [HOLD_W-1:0] hold_reg;
        logic              period_reg;
        logic              rpt_q;
        logic [HOLD_W-1:0] target;

        // The first repeat waits for the delay; every later one waits for the period.
        assign target = period_reg ? PERIOD_LAST : DELAY_LAST;

        // The hold counter runs while `out` is high and reloads on every
        // repeat, so it never overflows. The falling edge suppresses any
        // repeat due on the same cycle.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            hold_reg   <= '0;
            period_reg <= 1'b0;
            rpt_q      <= 1'b0;
          end else begin
            rpt_q <= 1'b0;
            if (!out_q || fall) begin
              hold_reg   <= '0;
              period_reg <= 1'b0;
            end else if (hold_reg == target) begin
              hold_reg   <= '0;
              period_reg <= 1'b1;
              rpt_q      <= 1'b1;
            end else begin
              hold_reg <= hold_reg + 1'b1;
            end
          end
        end

        assign rpt[gi] = rpt_q;
      end else begin : g_norep
        assign rpt[gi] = 1'b0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_button_bank.sv
// Scoreboard bench for button_bank. Stimulus tasks push the expected pulse
// events (cycle, kind, channel). A negedge monitor pops one event per pulse
// it sees and compares it against the expected event.
module tb_button_bank;
  localparam int CH = 4;
  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_RPT   = 2;
  localparam int LAT     = 7;   // sync stages + debounce cycles + 1
  localparam int RDELAY  = 10;
  localparam int RPERIOD = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] in_r = 4'b1000;
  logic [CH-1:0] out_w, pressed_w, released_w, rpt_w;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int cyc;
    int kind;
    int ch;
  } ev_t;
  ev_t exp_q[$];

  button_bank #(
    .CHANNELS(CH), .CLOCK_CYCLES(4), .SYNC_STAGES(2), .ACTIVE_LOW(4'b1000),
    .REPEAT_DELAY(RDELAY), .REPEAT_PERIOD(RPERIOD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in(in_r), .out(out_w),
    .pressed(pressed_w), .released(released_w), .rpt(rpt_w)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int c, int k, int ch);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.ch   = ch;
    exp_q.push_back(e);
  endfunction

  // Compare every observed pulse against the front of the scoreboard.
  always @(negedge clk) begin
    logic [CH-1:0] v;
    ev_t e;
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_pulse kind=%0d ch=%0d required at cycle %0d, not observed by cycle %0d",
                 exp_q[0].kind, exp_q[0].ch, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      for (int k = 0; k < 3; k++) begin
        v = (k == K_PRESS) ? pressed_w : (k == K_REL) ? released_w : rpt_w;
        for (int c = 0; c < CH; c++) begin
          if (v[c] === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_pulse actual kind=%0d ch=%0d cycle=%0d, required none", k, c, cyc);
            end else begin
              e = exp_q.pop_front();
              if (e.cyc != cyc || e.kind != k || e.ch != c) begin
                errors++;
                $display("FAIL pulse_event actual kind=%0d ch=%0d cycle=%0d, required kind=%0d ch=%0d cycle=%0d",
                         k, c, cyc, e.kind, e.ch, e.cyc);
              end
            end
          end
        end
      end
    end
  end

  task automatic check_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending actual %0d outstanding events, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (out_w !== 4'b0) begin errors++; $display("FAIL reset_out actual %b required 0000", out_w); end
    checks++;
    if (pressed_w !== 4'b0) begin errors++; $display("FAIL reset_pressed actual %b required 0000", pressed_w); end
    checks++;
    if (released_w !== 4'b0) begin errors++; $display("FAIL reset_released actual %b required 0000", released_w); end
    checks++;
    if (rpt_w !== 4'b0) begin errors++; $display("FAIL reset_rpt actual %b required 0000", rpt_w); end
    mon_en = 1'b1;
    rst_n  = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (out_w !== 4'b0) begin errors++; $display("FAIL idle_out actual %b required 0000", out_w); end
    check_empty("reset");
    $display("test_reset done at cycle %0d", cyc);
  endtask

  task automatic test_press_release();
    int n;
    @(negedge clk);
    n = cyc;
    in_r[0] = 1'b1;
    push(n + LAT, K_PRESS, 0);
    push(n + 2 * LAT, K_REL, 0);
    repeat (LAT - 1) @(negedge clk);
    checks++;
    if (out_w[0] !== 1'b0) begin errors++; $display("FAIL press_early actual %b required 0", out_w[0]); end
    @(negedge clk);
    checks++;
    if (out_w[0] !== 1'b1) begin errors++; $display("FAIL press_latency actual %b required 1", out_w[0]); end
    in_r[0] = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    checks++;
    if (out_w[0] !== 1'b1) begin errors++; $display("FAIL release_early actual %b required 1", out_w[0]); end
    @(negedge clk);
    checks++;
    if (out_w[0] !== 1'b0) begin errors++; $display("FAIL release_latency actual %b required 0", out_w[0]); end
    repeat (4) @(negedge clk);
    check_empty("press_release");
    $display("test_press_release done at cycle %0d", cyc);
  endtask

  task automatic test_glitch();
    in_r[1] = 1'b1;
    repeat (3) @(negedge clk);
    in_r[1] = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (out_w[1] !== 1'b0) begin errors++; $display("FAIL glitch_out actual %b required 0", out_w[1]); end
    check_empty("glitch");
    $display("test_glitch done at cycle %0d", cyc);
  endtask

  task automatic test_repeat();
    int p;
    int rel;
    @(negedge clk);
    p = cyc + LAT;
    rel = p + 30 + LAT;
    in_r[2] = 1'b1;
    push(p, K_PRESS, 2);
    for (int t = p + RDELAY; t < rel; t += RPERIOD) push(t, K_RPT, 2);
    push(rel, K_REL, 2);
    repeat (LAT + 30) @(negedge clk);
    checks++;
    if (out_w[2] !== 1'b1) begin errors++; $display("FAIL repeat_held_out actual %b required 1", out_w[2]); end
    in_r[2] = 1'b0;
    repeat (LAT + 5) @(negedge clk);
    checks++;
    if (out_w[2] !== 1'b0) begin errors++; $display("FAIL repeat_release_out actual %b required 0", out_w[2]); end
    check_empty("repeat");
    $display("test_repeat done at cycle %0d", cyc);
  endtask

  task automatic test_active_low();
    int m;
    @(negedge clk);
    rst_n = 1'b0;
    in_r  = 4'b0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m = cyc;
    push(m + LAT, K_PRESS, 3);
    push(m + 10 + LAT, K_REL, 3);
    repeat (LAT + 1) @(negedge clk);
    checks++;
    if (out_w !== 4'b1000) begin errors++; $display("FAIL active_low_out actual %b required 1000", out_w); end
    repeat (2) @(negedge clk);
    in_r[3] = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    checks++;
    if (out_w !== 4'b0000) begin errors++; $display("FAIL active_low_release actual %b required 0000", out_w); end
    check_empty("active_low");
    $display("test_active_low done at cycle %0d", cyc);
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    in_r[0] = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_w, pressed_w, released_w, rpt_w} !== 16'h0) begin
      errors++;
      $display("FAIL abort_async actual %h required 0000", {out_w, pressed_w, released_w, rpt_w});
    end
    repeat (2) @(negedge clk);
    in_r  = 4'b1000;
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (out_w !== 4'b0) begin errors++; $display("FAIL abort_out actual %b required 0000", out_w); end
    check_empty("reset_abort");
    $display("test_reset_abort done at cycle %0d", cyc);
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    n = cyc;
    in_r[1:0] = 2'b11;
    push(n + LAT, K_PRESS, 0);
    push(n + LAT, K_PRESS, 1);
    push(n + 2 * LAT, K_REL, 0);
    push(n + 2 * LAT, K_REL, 1);
    repeat (LAT) @(negedge clk);
    checks++;
    if (out_w !== 4'b0011) begin errors++; $display("FAIL simultaneous_out actual %b required 0011", out_w); end
    in_r[1:0] = 2'b00;
    repeat (LAT + 4) @(negedge clk);
    checks++;
    if (out_w !== 4'b0000) begin errors++; $display("FAIL simultaneous_release actual %b required 0000", out_w); end
    check_empty("back_to_back");
    $display("test_back_to_back done at cycle %0d", cyc);
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_glitch();
    test_repeat();
    test_active_low();
    test_reset_abort();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
